// File: rtl/pmix_code_ctrl.sv
// pmix_code_ctrl: phase-code controller for the CDR phase mixer
//   Turns early/late requests into a wrapping {sector, weight} mixer code with
//   registered one-hot phase-pair selects and complementary interpolation weights.
//   Optional second-order (frequency) path enabled by defining PMIX_FREQ_ACC_EN.
// Ports:
//   clk_i        block clock
//   rst_n_i      synchronous active-low reset
//   up_i/dn_i    advance/retard request, single cycle
//   step_i       code LSBs per accepted request
//   load_i       force code to load_code_i (ignores busy)
//   load_code_i  code to load
//   code_o       current mixer code {sector, weight}
//   sel_a_o      one-hot phase select, index = sector
//   sel_b_o      one-hot phase select, index = sector+1 mod NUM_PH
//   wt_a_o       FS - weight
//   wt_b_o       weight
//   busy_o       settle hold-off active, requests dropped
//   wrap_up_o    pulse: up move crossed max->0
//   wrap_dn_o    pulse: dn move crossed 0->max
//   freq_word_o  signed frequency integrator (0 without PMIX_FREQ_ACC_EN)
module pmix_code_ctrl #(
   parameter int SECTOR_BITS = 3,
   parameter int WEIGHT_BITS = 8,
   parameter int STEP_W      = 4,
   parameter int SETTLE_CYC  = 2,
   parameter int RST_CODE    = 0,
   parameter int FREQ_W      = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_n_i,
   input  logic                               up_i,
   input  logic                               dn_i,
   input  logic [STEP_W-1:0]                  step_i,
   input  logic                               load_i,
   input  logic [SECTOR_BITS+WEIGHT_BITS-1:0] load_code_i,
   output logic [SECTOR_BITS+WEIGHT_BITS-1:0] code_o,
   output logic [2**SECTOR_BITS-1:0]          sel_a_o,
   output logic [2**SECTOR_BITS-1:0]          sel_b_o,
   output logic [WEIGHT_BITS-1:0]             wt_a_o,
   output logic [WEIGHT_BITS-1:0]             wt_b_o,
   output logic                               busy_o,
   output logic                               wrap_up_o,
   output logic                               wrap_dn_o,
   output logic [FREQ_W-1:0]                  freq_word_o
);
   localparam int CW = SECTOR_BITS + WEIGHT_BITS;
   localparam int NUM_PH = 2**SECTOR_BITS;
   localparam int CNT_W = SETTLE_CYC > 0 ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [CW-1:0] RST_C = CW'(RST_CODE);

   logic [CW-1:0]    code_q, code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_up_d, wrap_dn_d;
   logic             idle, mv_up, mv_dn, do_up, do_dn, pend_up, pend_dn;
   logic [CW:0]      stp, sum, diff;

   function automatic logic [NUM_PH-1:0] onehot(input logic [SECTOR_BITS-1:0] s);
      return NUM_PH'(1) << s;
   endfunction

   assign code_o = code_q;

   always_comb begin
      // idle: a cycle where a pending fractional-path move may be applied
      idle = ~load_i & ~busy_o & ~up_i & ~dn_i;
      mv_up = ~load_i & ~busy_o & up_i & ~dn_i & (step_i != '0);
      mv_dn = ~load_i & ~busy_o & dn_i & ~up_i & (step_i != '0);
      do_up = mv_up | (idle & pend_up);
      do_dn = mv_dn | (idle & pend_dn);
      stp = (mv_up | mv_dn) ? {{(CW+1-STEP_W){1'b0}}, step_i} : (CW+1)'(1);
      // extra MSB of sum/diff is the modulo carry/borrow
      sum = {1'b0, code_q} + stp;
      diff = {1'b0, code_q} - stp;
      code_d = load_i ? load_code_i : do_up ? sum[CW-1:0] : do_dn ? diff[CW-1:0] : code_q;
      wrap_up_d = do_up & sum[CW];
      wrap_dn_d = do_dn & diff[CW];
      cnt_d = (load_i | do_up | do_dn) ? CNT_W'(SETTLE_CYC) : busy_o ? cnt_q - CNT_W'(1) : '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         code_q    <= RST_C;
         cnt_q     <= '0;
         busy_o    <= 1'b0;
         wrap_up_o <= 1'b0;
         wrap_dn_o <= 1'b0;
         sel_a_o   <= onehot(RST_C[CW-1:WEIGHT_BITS]);
         sel_b_o   <= onehot(RST_C[CW-1:WEIGHT_BITS] + SECTOR_BITS'(1));
         wt_b_o    <= RST_C[WEIGHT_BITS-1:0];
         wt_a_o    <= ~RST_C[WEIGHT_BITS-1:0];
      end else begin
         code_q    <= code_d;
         cnt_q     <= cnt_d;
         busy_o    <= cnt_d != '0;
         wrap_up_o <= wrap_up_d;
         wrap_dn_o <= wrap_dn_d;
         sel_a_o   <= onehot(code_d[CW-1:WEIGHT_BITS]);
         sel_b_o   <= onehot(code_d[CW-1:WEIGHT_BITS] + SECTOR_BITS'(1));
         wt_b_o    <= code_d[WEIGHT_BITS-1:0];
         // FS - w equals bitwise inversion for FS = 2**WEIGHT_BITS-1
         wt_a_o    <= ~code_d[WEIGHT_BITS-1:0];
      end
   end

`ifdef PMIX_FREQ_ACC_EN
   localparam int AW = (WEIGHT_BITS > FREQ_W ? WEIGHT_BITS : FREQ_W) + 2;
   localparam logic signed [FREQ_W-1:0] F_MAX = {1'b0, {(FREQ_W-1){1'b1}}};
   localparam logic signed [FREQ_W-1:0] F_MIN = {1'b1, {(FREQ_W-1){1'b0}}};

   logic signed [FREQ_W-1:0] freq_q, freq_d;
   logic [WEIGHT_BITS-1:0]   acc_q, acc_d;
   logic                     pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
   logic signed [AW-1:0]     acc_sum;
   logic                     carry, borrow;

   assign pend_up = pend_up_q;
   assign pend_dn = pend_dn_q;
   assign freq_word_o = freq_q;

   always_comb begin
      freq_d = (mv_up && freq_q != F_MAX) ? freq_q + FREQ_W'(1) :
               (mv_dn && freq_q != F_MIN) ? freq_q - FREQ_W'(1) : freq_q;
      acc_sum = $signed(AW'(acc_q)) + AW'(freq_q);
      carry = ~acc_sum[AW-1] & (|acc_sum[AW-2:WEIGHT_BITS]);
      borrow = acc_sum[AW-1];
      acc_d = load_i ? '0 : acc_sum[WEIGHT_BITS-1:0];
      // a pending move is consumed on an idle cycle; a fresh carry/borrow replaces it
      pend_up_d = ~load_i & ~borrow & (carry | (pend_up_q & ~idle));
      pend_dn_d = ~load_i & ~carry & (borrow | (pend_dn_q & ~idle));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         freq_q    <= '0;
         acc_q     <= '0;
         pend_up_q <= 1'b0;
         pend_dn_q <= 1'b0;
      end else begin
         freq_q    <= freq_d;
         acc_q     <= acc_d;
         pend_up_q <= pend_up_d;
         pend_dn_q <= pend_dn_d;
      end
   end
`else
   assign pend_up = 1'b0;
   assign pend_dn = 1'b0;
   assign freq_word_o = '0;
`endif
endmodule
